decode_wide: RTL and testbench

DECODE_WIDE -- requirements
Module: decode_wide

---
 rtl/decode_wide_pkg.sv | 67 ++++++
 rtl/decode_wide_lane.sv | 103 ++++++++++
 rtl/decode_wide.sv | 106 ++++++++++
 tb/tb_decode_wide.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_wide_pkg.sv
// Shared decode types and immediate extraction for the wide RV32I decoder.
// DECODE_ILLEGAL_CHECK_EN (optional) enables illegal flagging and group squash.
package instr_decode;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} t_fmt;

  typedef enum logic [3:0] {
    UOP_NONE, UOP_ALU, UOP_ALUI, UOP_LOAD, UOP_STORE,
    UOP_BRANCH, UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR
  } t_uop;

  typedef enum logic [1:0] {OP_NONE, OP_REG, OP_IMM} t_opnd_type;
  typedef enum logic [1:0] {SZ_NONE, SZ_1B, SZ_2B, SZ_4B} t_opsize;

  typedef struct packed {
    t_opnd_type typ;
    logic [4:0] idx;
    t_opsize    size;
  } t_uopnd_descr;

  typedef struct packed {
    logic [31:0] instr;
  } t_instr_pkt;

  typedef struct packed {
    logic         valid;
    logic         illegal;
    t_uop         uop;
    t_fmt         fmt;
    logic [2:0]   funct3;
    logic [31:0]  imm32;
    t_uopnd_descr dst;
    t_uopnd_descr src1;
    t_uopnd_descr src2;
  } t_uinstr;

  function automatic t_uopnd_descr reg_opnd(input logic [4:0] idx);
    return '{typ: OP_REG, idx: idx, size: SZ_4B};
  endfunction

  function automatic t_uopnd_descr imm_opnd();
    return '{typ: OP_IMM, idx: 5'd0, size: SZ_4B};
  endfunction

  // Sign-extended immediate for a format; takes instr[31:7] (opcode bits never feed an immediate).
  function automatic logic [31:0] imm_extract(input t_fmt fmt, input logic [31:7] b);
    case (fmt)
      FMT_I:   return {{20{b[31]}}, b[31:20]};
      FMT_S:   return {{20{b[31]}}, b[31:25], b[11:7]};
      FMT_B:   return {{19{b[31]}}, b[31], b[7], b[30:25], b[11:8], 1'b0};
      FMT_U:   return {b[31:12], 12'b0};
      FMT_J:   return {{11{b[31]}}, b[31], b[19:12], b[20], b[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_wide_lane.sv
// Single-lane combinational RV32I decode into a t_uinstr.
// DECODE_ILLEGAL_CHECK_EN drives .illegal from opcode/funct legality; otherwise it is 0.
module decode_lane
  import instr_decode::*;
(
  input  logic       valid_i,
  input  t_instr_pkt pkt_i,
  output t_uinstr    uinstr_o
);

  logic [31:0] ins;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  t_uop        uop;
  t_fmt        fmt;
  logic        ill;

  assign ins = pkt_i.instr;
  assign opc = ins[6:0];
  assign rd  = ins[11:7];
  assign f3  = ins[14:12];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign f7  = ins[31:25];

  always_comb begin
    uop = UOP_NONE;
    fmt = FMT_NONE;
    ill = 1'b0;
    case (opc)
      OPC_OP: begin
        uop = UOP_ALU;    fmt = FMT_R;
        ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        uop = UOP_ALUI;   fmt = FMT_I;
        ill = (f3 == 3'b001 && f7 != 7'h00) ||
              (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPC_LOAD: begin
        uop = UOP_LOAD;   fmt = FMT_I;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_JALR: begin
        uop = UOP_JALR;   fmt = FMT_I;
        ill = (f3 != 3'b000);
      end
      OPC_STORE: begin
        uop = UOP_STORE;  fmt = FMT_S;
        ill = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        uop = UOP_BRANCH; fmt = FMT_B;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LUI:   begin uop = UOP_LUI;   fmt = FMT_U; end
      OPC_AUIPC: begin uop = UOP_AUIPC; fmt = FMT_U; end
      OPC_JAL:   begin uop = UOP_JAL;   fmt = FMT_J; end
      default:   ill = 1'b1;
    endcase
  end

  always_comb begin
    uinstr_o       = '0;
    uinstr_o.uop   = uop;
    uinstr_o.fmt   = fmt;
    uinstr_o.imm32 = imm_extract(fmt, ins[31:7]);
    case (fmt)
      FMT_R: begin
        uinstr_o.dst  = reg_opnd(rd);
        uinstr_o.src1 = reg_opnd(rs1);
        uinstr_o.src2 = reg_opnd(rs2);
      end
      FMT_I: begin
        uinstr_o.dst  = reg_opnd(rd);
        uinstr_o.src1 = reg_opnd(rs1);
        uinstr_o.src2 = imm_opnd();
      end
      FMT_S, FMT_B: begin
        uinstr_o.src1 = reg_opnd(rs1);
        uinstr_o.src2 = reg_opnd(rs2);
      end
      FMT_U, FMT_J: begin
        uinstr_o.dst  = reg_opnd(rd);
        uinstr_o.src2 = imm_opnd();
      end
      default: ;
    endcase
    if (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) uinstr_o.funct3 = f3;
    uinstr_o.valid = 1'b1;
`ifdef DECODE_ILLEGAL_CHECK_EN
    uinstr_o.illegal = ill;
`endif
    if (!valid_i) uinstr_o = '0;
  end

`ifndef DECODE_ILLEGAL_CHECK_EN
  logic unused_ill;
  assign unused_ill = ill;
`endif

endmodule

// File: rtl/decode_wide.sv
// WIDTH-lane decoder feeding a DEPTH-entry queue of decoded groups.
// DECODE_ILLEGAL_CHECK_EN squashes lanes above the first illegal lane in a group.
module decode_wide
  import instr_decode::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic       [WIDTH-1:0] valid_fe1,
  input  t_instr_pkt [WIDTH-1:0] instr_fe1,
  output logic                   ready_fe1,
  output logic                   valid_de1,
  output t_uinstr    [WIDTH-1:0] uinstr_de1,
  input  logic                   ready_de1
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int VW    = WIDTH + 1;

  logic [WIDTH-1:0]               lane_vld;
  t_uinstr [WIDTH-1:0]            lane_dec, grp;
  t_uinstr [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           full, empty, enq, deq;

  // A lane is live only if every lane below it is valid, so a hole drops the rest.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign lane_vld[g] = &valid_fe1[g:0];
    decode_lane u_lane (
      .valid_i  (lane_vld[g]),
      .pkt_i    (instr_fe1[g]),
      .uinstr_o (lane_dec[g])
    );
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  always_comb begin
    logic kill;
    grp  = lane_dec;
    kill = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (kill) grp[i] = '0;
      kill = kill | lane_dec[i].illegal;
    end
  end
`else
  assign grp = lane_dec;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign ready_fe1  = ~full & ~reset;
  assign valid_de1  = ~empty & ~reset;
  assign enq        = ready_fe1 & (|valid_fe1);
  assign deq        = valid_de1 & ready_de1;
  assign uinstr_de1 = valid_de1 ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = grp;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility and enq is blocked during reset.
  always_ff @(posedge clk) mem_q <= mem_d;

`ifndef SYNTHESIS
  a_no_enq_full: assert property (@(posedge clk) disable iff (reset) full |-> !enq);
  a_contig: assert property (@(posedge clk) disable iff (reset)
    (VW'(valid_fe1) & (VW'(valid_fe1) + VW'(1))) == '0);
  a_hold: assert property (@(posedge clk) disable iff (reset)
    (valid_de1 && !ready_de1) |=> $stable(uinstr_de1));
`endif

endmodule

// File: tb/tb_decode_wide.sv
// Scoreboard bench for decode_wide (WIDTH=2, DEPTH=4); expectations follow
// DECODE_ILLEGAL_CHECK_EN when it is defined.
module tb_decode_wide;
  import instr_decode::*;

  typedef t_uinstr [1:0] t_grp;

  localparam logic [31:0] I_ADDI = 32'hFFF10093;
  localparam logic [31:0] I_SW   = 32'h00512423;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_JAL  = 32'h001000EF;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_ZERO = 32'h00000000;

  logic                 clk, reset;
  logic       [1:0]     valid_fe1;
  t_instr_pkt [1:0]     instr_fe1;
  logic                 ready_fe1, valid_de1, ready_de1;
  t_uinstr    [1:0]     uinstr_de1;

  t_grp    sb[$];
  t_grp    exp_in;
  int      n_chk, n_err, n_acc;
  t_uinstr e_addi, e_sw, e_beq, e_lui, e_jal, e_add, e_mul, e_zero, e_sq;
  logic [31:0] tbl_i[6];
  t_uinstr     tbl_e[6];

  decode_wide #(.WIDTH(2), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_fe1  (valid_fe1),
    .instr_fe1  (instr_fe1),
    .ready_fe1  (ready_fe1),
    .valid_de1  (valid_de1),
    .uinstr_de1 (uinstr_de1),
    .ready_de1  (ready_de1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic t_uopnd_descr rg(input logic [4:0] i);
    return '{typ: OP_REG, idx: i, size: SZ_4B};
  endfunction

  function automatic t_uopnd_descr im();
    return '{typ: OP_IMM, idx: 5'd0, size: SZ_4B};
  endfunction

  function automatic t_uinstr ex(input t_uop u, input t_fmt f, input logic [2:0] f3,
                                 input logic [31:0] imm, input t_uopnd_descr d,
                                 input t_uopnd_descr s1, input t_uopnd_descr s2);
    t_uinstr r;
    r = '0;
    r.valid = 1'b1; r.uop = u; r.fmt = f; r.funct3 = f3; r.imm32 = imm;
    r.dst = d; r.src1 = s1; r.src2 = s2;
    return r;
  endfunction

  // Scoreboard: pop/compare first (head is always older), then record accepted groups.
  always @(negedge clk) begin
    if (valid_de1 && ready_de1) begin
      if (sb.size() == 0) chk("spurious_out", 256'(1), 256'(0));
      else begin
        t_grp e;
        e = sb.pop_front();
        chk("grp_out", 256'(uinstr_de1), 256'(e));
      end
    end
    if (!reset && ready_fe1 && |valid_fe1) begin
      sb.push_back(exp_in);
      n_acc++;
    end
  end

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic to_pos();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] vm,
                        input t_uinstr e0, input t_uinstr e1);
    instr_fe1[0].instr = i0;
    instr_fe1[1].instr = i1;
    valid_fe1 = vm;
    exp_in = {(vm[1] ? e1 : t_uinstr'('0)), e0};
  endtask

  task automatic send(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] vm,
                      input t_uinstr e0, input t_uinstr e1);
    int n;
    n = 0;
    set_in(i0, i1, vm, e0, e1);
    do begin at_neg(); n++; end while (!ready_fe1 && n < 50);
    if (!ready_fe1) chk("send_timeout", 256'(0), 256'(1));
    to_pos();
    valid_fe1 = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_de1 = 1'b1;
    valid_fe1 = '0;
    while (sb.size() != 0 && n < 100) begin at_neg(); n++; end
    chk("drain", 256'(sb.size()), 256'(0));
    at_neg();
    chk("empty_vld", 256'(valid_de1), 256'(0));
    chk("empty_zero", 256'(uinstr_de1), 256'(0));
    to_pos();
  endtask

  initial begin
    int n0, k;
    logic hold;
    n_chk = 0; n_err = 0; n_acc = 0;
    e_addi = ex(UOP_ALUI,   FMT_I, 3'd0, 32'hFFFFFFFF, rg(1), rg(2), im());
    e_sw   = ex(UOP_STORE,  FMT_S, 3'd2, 32'h00000008, '0,    rg(2), rg(5));
    e_beq  = ex(UOP_BRANCH, FMT_B, 3'd0, 32'hFFFFFFFC, '0,    rg(0), rg(0));
    e_lui  = ex(UOP_LUI,    FMT_U, 3'd0, 32'h12345000, rg(1), '0,    im());
    e_jal  = ex(UOP_JAL,    FMT_J, 3'd0, 32'h00000800, rg(1), '0,    im());
    e_add  = ex(UOP_ALU,    FMT_R, 3'd0, 32'h00000000, rg(3), rg(1), rg(2));
    e_mul  = e_add;
    e_zero = '0;
    e_zero.valid = 1'b1;
`ifdef DECODE_ILLEGAL_CHECK_EN
    e_mul.illegal  = 1'b1;
    e_zero.illegal = 1'b1;
    e_sq = '0;
`else
    e_sq = e_addi;
`endif
    tbl_i = '{I_ADDI, I_SW, I_BEQ, I_LUI, I_JAL, I_ADD};
    tbl_e = '{e_addi, e_sw, e_beq, e_lui, e_jal, e_add};

    reset = 1'b1; valid_fe1 = '0; instr_fe1 = '0; ready_de1 = 1'b1; exp_in = '0;
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_ready", 256'(ready_fe1), 256'(0));
    chk("rst_valid", 256'(valid_de1), 256'(0));
    chk("rst_uinstr", 256'(uinstr_de1), 256'(0));
    to_pos();
    reset = 1'b0;
    at_neg();
    chk("ready_after_rst", 256'(ready_fe1), 256'(1));
    to_pos();

    // addi on lane 0 only; visible the cycle after acceptance
    send(I_ADDI, I_ZERO, 2'b01, e_addi, '0);
    at_neg();
    chk("latency_n1", 256'(valid_de1), 256'(1));
    to_pos();
    send(I_SW,  I_BEQ, 2'b11, e_sw,  e_beq);
    send(I_LUI, I_JAL, 2'b11, e_lui, e_jal);
    send(I_ADD, I_SW,  2'b11, e_add, e_sw);
    send(I_ZERO, I_ADDI, 2'b11, e_zero, e_sq);
    send(I_MUL,  I_ADDI, 2'b11, e_mul,  e_sq);
    drain();

    // backpressure: fill, hold, then no-bypass when full
    ready_de1 = 1'b0;
    n0 = n_acc;
    send(I_ADD, I_ADDI, 2'b11, e_add, e_addi);
    send(I_SW,  I_BEQ,  2'b11, e_sw,  e_beq);
    send(I_LUI, I_JAL,  2'b11, e_lui, e_jal);
    send(I_JAL, I_LUI,  2'b11, e_jal, e_lui);
    set_in(I_BEQ, I_SW, 2'b11, e_beq, e_sw);
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("full_ready", 256'(ready_fe1), 256'(0));
      chk("head_hold", 256'(uinstr_de1), 256'({e_addi, e_add}));
      to_pos();
    end
    chk("accepted4", 256'(n_acc - n0), 256'(4));
    ready_de1 = 1'b1;
    at_neg();
    chk("no_bypass", 256'(ready_fe1), 256'(0));
    to_pos();
    at_neg();
    chk("accept_next", 256'(ready_fe1), 256'(1));
    to_pos();
    valid_fe1 = '0;
    chk("accepted5", 256'(n_acc - n0), 256'(5));
    drain();

    // reset with queued groups
    ready_de1 = 1'b0;
    send(I_ADD, I_SW,  2'b11, e_add, e_sw);
    send(I_LUI, I_JAL, 2'b11, e_lui, e_jal);
    send(I_BEQ, I_ADD, 2'b11, e_beq, e_add);
    reset = 1'b1;
    at_neg();
    chk("rstmid_valid", 256'(valid_de1), 256'(0));
    chk("rstmid_ready", 256'(ready_fe1), 256'(0));
    chk("rstmid_uinstr", 256'(uinstr_de1), 256'(0));
    to_pos();
    reset = 1'b0;
    sb.delete();
    at_neg();
    chk("rst_flush", 256'(valid_de1), 256'(0));
    chk("rst_ready1", 256'(ready_fe1), 256'(1));
    to_pos();
    ready_de1 = 1'b1;
    send(I_JAL, I_LUI, 2'b11, e_jal, e_lui);
    drain();

    // random backpressure across pointer wrap
    k = 0; hold = 1'b0;
    for (int c = 0; c < 80 && k < 14; c++) begin
      if (!hold) begin
        int a, b;
        a = $urandom_range(0, 5);
        b = $urandom_range(0, 5);
        set_in(tbl_i[a], tbl_i[b], ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01, tbl_e[a], tbl_e[b]);
      end
      ready_de1 = ($urandom_range(0, 1) != 0);
      at_neg();
      hold = !ready_fe1;
      if (!hold) k++;
      to_pos();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
